// File: rtl/ysyx_220053_div_unit.sv
// ysyx_220053_div_unit: iterative radix-2 restoring divider for RV64M div/rem and W forms
module ysyx_220053_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            div_signed,
    input  logic            div_word,
    input  logic            div_rem,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int H  = XLEN / 2;
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] rem_q, rem_d, quot_q, quot_d, b_q, b_d, result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q_q, neg_q_d, neg_r_q, neg_r_d, word_q, word_d, sel_rem_q, sel_rem_d;

    logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, sp_res;
    logic [XLEN-1:0] rem_n, quot_n, fin, fin_res;
    logic [XLEN:0]   sh;
    logic            a_neg, b_neg, div_zero, ovf, special, accept, ge;

    function automatic logic [XLEN-1:0] sx(input logic [XLEN-1:0] v);
        return {{H{v[H-1]}}, v[H-1:0]};
    endfunction

    assign in_ready  = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign accept    = in_valid & in_ready & ~flush;

    // Operand extension, magnitudes and the special-case results that skip iteration
    always_comb begin
        a_ext    = div_word ? (div_signed ? sx(dividend) : {{H{1'b0}}, dividend[H-1:0]}) : dividend;
        b_ext    = div_word ? (div_signed ? sx(divisor) : {{H{1'b0}}, divisor[H-1:0]}) : divisor;
        a_neg    = div_signed & a_ext[XLEN-1];
        b_neg    = div_signed & b_ext[XLEN-1];
        a_mag    = a_neg ? -a_ext : a_ext;
        b_mag    = b_neg ? -b_ext : b_ext;
        min_val  = div_word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = b_ext == '0;
        ovf      = div_signed & (a_ext == min_val) & (&b_ext);
        special  = div_zero | ovf;
        sp_res   = div_zero ? (div_rem ? a_ext : '1) : (div_rem ? '0 : a_ext);
        sp_res   = div_word ? sx(sp_res) : sp_res;
    end

    // One restoring step plus sign fix-up of the final step's values
    always_comb begin
        sh      = {rem_q, quot_q[XLEN-1]};
        ge      = sh >= {1'b0, b_q};
        rem_n   = ge ? sh[XLEN-1:0] - b_q : sh[XLEN-1:0];
        quot_n  = {quot_q[XLEN-2:0], ge};
        fin     = sel_rem_q ? (neg_r_q ? -rem_n : rem_n) : (neg_q_q ? -quot_n : quot_n);
        fin_res = word_q ? sx(fin) : fin;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    // Datapath: latch operands on accept, iterate in CALC, capture the result
    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        word_d    = word_q;
        sel_rem_d = sel_rem_q;
        result_d  = result_q;
        if (accept) begin
            rem_d     = '0;
            quot_d    = div_word ? {a_mag[H-1:0], {H{1'b0}}} : a_mag;
            b_d       = b_mag;
            cnt_d     = div_word ? CW'(H - 1) : CW'(XLEN - 1);
            neg_q_d   = a_neg ^ b_neg;
            neg_r_d   = a_neg;
            word_d    = div_word;
            sel_rem_d = div_rem;
            if (special) result_d = sp_res;
        end else if (state_q == CALC && !flush) begin
            rem_d  = rem_n;
            quot_d = quot_n;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == '0) result_d = fin_res;
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quot_q    <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            word_q    <= 1'b0;
            sel_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            word_q    <= word_d;
            sel_rem_q <= sel_rem_d;
            result_q  <= result_d;
        end
    end
endmodule
